// File: rtl/avalon_mm_protocol_checker.sv
// Passive Avalon-MM slave-side protocol checker.
// Watches one Avalon-MM interface and records protocol violations in sticky
// flags, a first-error code and a saturating error counter. It also tracks how
// many read beats are still outstanding.
// Transfer modes (AVALONMODE):
//   0 = waitrequest only
//   1 = fixed read latency
//   2 = pipelined variable latency
//   3 = burst
// Optional feature macro: AVM_CHECKER_STATS_EN adds the rd_count/wr_count
// command counters. When it is undefined, both counters are tied to zero.
// Flag bits:
//   0 RW_OVERLAP, 1 UNSTABLE, 2 WAIT_IDLE, 3 RDV_UNEXPECTED, 4 OVERFLOW,
//   5 LATENCY, 6 BURST
module avalon_mm_protocol_checker #(
  parameter int AVALONMODE  = 0,
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int FIXEDDELAY  = 2,
  parameter int MAXPENDING  = 8,
  parameter int ERRCNTW     = 16,
  localparam int PW         = $clog2(MAXPENDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBADDRBITS-1:0]    address,
  input  logic [NBDATABYTES-1:0]   byteenable,
  input  logic [8*NBDATABYTES-1:0] readdata,
  input  logic [8*NBDATABYTES-1:0] writedata,
  input  logic                     read,
  input  logic                     write,
  input  logic                     waitrequest,
  input  logic                     readdatavalid,
  input  logic [7:0]               burstcount,
  input  logic                     beginbursttransfer,
  input  logic                     clear,
  output logic [6:0]               err_flags,
  output logic [2:0]               err_first,
  output logic [ERRCNTW-1:0]       err_count,
  output logic [PW-1:0]            pending,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
);

  // Arithmetic width with enough headroom for pending plus a full 8-bit burst.
  localparam int SW = PW + 10;

  // Width of the command snapshot that must stay stable while the slave stalls.
  localparam int CW = NBADDRBITS + NBDATABYTES + 2 + 8*NBDATABYTES;

  logic                  rd_accept;
  logic                  wr_accept;
  logic                  any_cmd;
  logic [SW-1:0]         beats;
  logic [SW-1:0]         inc;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         nxt;
  logic                  dec;
  logic [6:0]            det;
  logic [2:0]            first_idx;
  logic [CW-1:0]         cur_cmd;
  logic [CW-1:0]         prev_cmd;
  logic                  prev_wait;
  logic [FIXEDDELAY-1:0] lat_sr;
  logic                  unused_sink;

  assign cur_cmd = {address, byteenable, read, write, writedata};

  // readdata is never inspected. Mode-specific inputs may go unused in some
  // builds, so they are folded into this sink to keep lint quiet.
  assign unused_sink = ^{readdata, wr_accept, burstcount, beginbursttransfer,
                         readdatavalid, lat_sr};

  // Decode acceptance, the pending-beat arithmetic and this cycle's violation vector.
  always_comb begin
    any_cmd   = read | write;
    rd_accept = read & ~waitrequest;
    wr_accept = write & ~waitrequest;
    beats     = (AVALONMODE == 3) ? SW'(burstcount) : SW'(1);
    inc       = rd_accept ? beats : '0;
    dec       = readdatavalid && (pending != '0);
    sum       = SW'(pending) + inc;
    nxt       = sum - SW'(dec);
    det       = '0;
    det[0]    = read & write;
    det[1]    = prev_wait && (cur_cmd != prev_cmd);
    det[2]    = waitrequest & ~any_cmd;
    if (AVALONMODE != 0) begin
      det[3] = readdatavalid && (pending == '0);
      det[4] = rd_accept && (sum > SW'(MAXPENDING));
    end
    if (AVALONMODE == 1) begin
      det[5] = readdatavalid != lat_sr[FIXEDDELAY-1];
    end
    if (AVALONMODE == 3) begin
      det[6] = (beginbursttransfer & ~any_cmd) |
               (beginbursttransfer & (burstcount == 8'd0)) |
               (any_cmd & (burstcount == 8'd0));
    end
    first_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (det[i]) first_idx = 3'(i);
    end
  end

  // Sticky flags, first-error code and saturating counter; clear overrides new errors.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_flags <= '0;
      err_first <= 3'd7;
      err_count <= '0;
    end else begin
      err_flags <= err_flags | det;
      if ((err_first == 3'd7) && (det != '0)) err_first <= first_idx;
      if ((det != '0) && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  // Remember the last command and the read-acceptance history for the
  // stability and fixed-latency checks.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_cmd  <= '0;
      prev_wait <= 1'b0;
      lat_sr    <= '0;
    end else begin
      prev_cmd  <= cur_cmd;
      prev_wait <= any_cmd & waitrequest;
      lat_sr    <= (lat_sr << 1) | FIXEDDELAY'(rd_accept);
    end
  end

  // Outstanding read beats: add the accepted burst, retire one beat per
  // return, and clamp at MAXPENDING.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (AVALONMODE == 0) begin
      pending <= '0;
    end else if (nxt > SW'(MAXPENDING)) begin
      pending <= PW'(MAXPENDING);
    end else begin
      pending <= nxt[PW-1:0];
    end
  end

`ifdef AVM_CHECKER_STATS_EN
  logic [7:0] wr_left;

  // Count accepted commands. A burst counts once, so in burst mode the
  // remaining write beats of the current burst are skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
      wr_left  <= '0;
    end else begin
      if (rd_accept) rd_count <= rd_count + 32'd1;
      if (wr_accept) begin
        if ((AVALONMODE != 3) || (wr_left == 8'd0)) begin
          wr_count <= wr_count + 32'd1;
          if (AVALONMODE == 3) wr_left <= (burstcount == 8'd0) ? 8'd0 : burstcount - 8'd1;
        end else begin
          wr_left <= wr_left - 8'd1;
        end
      end
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_avalon_mm_protocol_checker.sv
// Directed self-checking bench for avalon_mm_protocol_checker.
// Four checker instances share one snooped bus: mode 0, mode 1 with
// FIXEDDELAY=2, mode 2 with MAXPENDING=4, and mode 3. Each scenario starts
// from reset and checks only the instance it targets.
// When AVM_CHECKER_STATS_EN is defined, the command counters are expected to
// count; otherwise they are expected to read zero.
module tb_avalon_mm_protocol_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  address;
  logic [1:0]  byteenable;
  logic [15:0] readdata;
  logic [15:0] writedata;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic        readdatavalid;
  logic [7:0]  burstcount;
  logic        beginbursttransfer;
  logic        clear;

  logic [6:0]  m0_flags, m1_flags, m2_flags, m3_flags;
  logic [2:0]  m0_first, m1_first, m2_first, m3_first;
  logic [15:0] m0_count, m1_count, m2_count, m3_count;
  logic [3:0]  m0_pend, m1_pend, m3_pend;
  logic [2:0]  m2_pend;
  logic [31:0] m0_rdc, m0_wrc, m1_rdc, m1_wrc, m2_rdc, m2_wrc, m3_rdc, m3_wrc;

  int test_count = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  avalon_mm_protocol_checker #(.AVALONMODE(0)) u_m0 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable),
    .readdata(readdata), .writedata(writedata), .read(read), .write(write),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .clear(clear), .err_flags(m0_flags), .err_first(m0_first),
    .err_count(m0_count), .pending(m0_pend), .rd_count(m0_rdc), .wr_count(m0_wrc));

  avalon_mm_protocol_checker #(.AVALONMODE(1), .FIXEDDELAY(2)) u_m1 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable),
    .readdata(readdata), .writedata(writedata), .read(read), .write(write),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .clear(clear), .err_flags(m1_flags), .err_first(m1_first),
    .err_count(m1_count), .pending(m1_pend), .rd_count(m1_rdc), .wr_count(m1_wrc));

  avalon_mm_protocol_checker #(.AVALONMODE(2), .MAXPENDING(4)) u_m2 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable),
    .readdata(readdata), .writedata(writedata), .read(read), .write(write),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .clear(clear), .err_flags(m2_flags), .err_first(m2_first),
    .err_count(m2_count), .pending(m2_pend), .rd_count(m2_rdc), .wr_count(m2_wrc));

  avalon_mm_protocol_checker #(.AVALONMODE(3)) u_m3 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable),
    .readdata(readdata), .writedata(writedata), .read(read), .write(write),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .clear(clear), .err_flags(m3_flags), .err_first(m3_first),
    .err_count(m3_count), .pending(m3_pend), .rd_count(m3_rdc), .wr_count(m3_wrc));

  // Drive one bus cycle, then step to just after the rising edge.
  task automatic applyStimulus(input logic r, input logic w, input logic wreq,
                               input logic rdv, input logic [7:0] addr,
                               input logic bbt, input logic [7:0] bc);
    read               = r;
    write              = w;
    waitrequest        = wreq;
    readdatavalid      = rdv;
    address            = addr;
    beginbursttransfer = bbt;
    burstcount         = bc;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold reset for two cycles with the bus idle.
  task automatic doReset();
    rst   = 1'b1;
    clear = 1'b0;
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    rst = 1'b1; clear = 1'b0; read = 1'b0; write = 1'b0; waitrequest = 1'b0;
    readdatavalid = 1'b0; address = 8'h00; byteenable = 2'b11;
    readdata = 16'hA5A5; writedata = 16'h1234; burstcount = 8'd1;
    beginbursttransfer = 1'b0;

    // Reset state.
    doReset();
    checkOutput("rst_flags", 32'(m0_flags), 32'h00);
    checkOutput("rst_first", 32'(m0_first), 32'd7);
    checkOutput("rst_count", 32'(m0_count), 32'd0);
    checkOutput("rst_pend1", 32'(m1_pend), 32'd0);

    // Mode 0: the address changes while the read is stalled.
    applyStimulus(1, 0, 1, 0, 8'h10, 0, 8'd1);
    applyStimulus(1, 0, 1, 0, 8'h11, 0, 8'd1);
    applyStimulus(1, 0, 1, 0, 8'h11, 0, 8'd1);
    applyStimulus(1, 0, 0, 0, 8'h11, 0, 8'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    checkOutput("unst_flags", 32'(m0_flags), 32'h02);
    checkOutput("unst_first", 32'(m0_first), 32'd1);
    checkOutput("unst_count", 32'(m0_count), 32'd1);
    checkOutput("m0_pending", 32'(m0_pend), 32'd0);

    // Mode 0: read and write overlap, then a clear pulse; clear also wins
    // over an overlap in the same cycle.
    doReset();
    applyStimulus(1, 1, 0, 0, 8'h20, 0, 8'd1);
    applyStimulus(1, 1, 0, 0, 8'h20, 0, 8'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    checkOutput("ovl_flags", 32'(m0_flags), 32'h01);
    checkOutput("ovl_first", 32'(m0_first), 32'd0);
    checkOutput("ovl_count", 32'(m0_count), 32'd2);
    clear = 1'b1;
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    clear = 1'b0;
    checkOutput("clr_flags", 32'(m0_flags), 32'h00);
    checkOutput("clr_first", 32'(m0_first), 32'd7);
    checkOutput("clr_count", 32'(m0_count), 32'd0);
    clear = 1'b1;
    applyStimulus(1, 1, 0, 0, 8'h20, 0, 8'd1);
    clear = 1'b0;
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    checkOutput("clrwin_flags", 32'(m0_flags), 32'h00);
    checkOutput("clrwin_count", 32'(m0_count), 32'd0);

    // Mode 1: data returns on time, then one cycle late.
    doReset();
    applyStimulus(1, 0, 0, 0, 8'h30, 0, 8'd1);
    checkOutput("lat_pend1", 32'(m1_pend), 32'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    applyStimulus(0, 0, 0, 1, 8'h00, 0, 8'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    checkOutput("lat_ok_flags", 32'(m1_flags), 32'h00);
    checkOutput("lat_ok_pend", 32'(m1_pend), 32'd0);
    applyStimulus(1, 0, 0, 0, 8'h30, 0, 8'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    applyStimulus(0, 0, 0, 1, 8'h00, 0, 8'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    checkOutput("lat_bad_flags", 32'(m1_flags), 32'h20);
    checkOutput("lat_bad_first", 32'(m1_first), 32'd5);
    checkOutput("lat_bad_count", 32'(m1_count), 32'd2);
    checkOutput("lat_bad_pend", 32'(m1_pend), 32'd0);

    // Mode 2: five reads overflow a depth of four, then five returns.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 8'(i), 0, 8'd1);
    checkOutput("ovf_pend4", 32'(m2_pend), 32'd4);
    checkOutput("ovf_none", 32'(m2_flags), 32'h00);
    applyStimulus(1, 0, 0, 0, 8'h04, 0, 8'd1);
    checkOutput("ovf_sat", 32'(m2_pend), 32'd4);
    checkOutput("ovf_flags", 32'(m2_flags), 32'h10);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 8'h00, 0, 8'd1);
    checkOutput("rdv_pend0", 32'(m2_pend), 32'd0);
    checkOutput("rdv_noflag", 32'(m2_flags), 32'h10);
    applyStimulus(0, 0, 0, 1, 8'h00, 0, 8'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    checkOutput("rdv_flags", 32'(m2_flags), 32'h18);
    checkOutput("rdv_first", 32'(m2_first), 32'd4);
    checkOutput("rdv_count", 32'(m2_count), 32'd2);
    checkOutput("rdv_pend", 32'(m2_pend), 32'd0);

    // Mode 3: a legal four-beat burst, then a burst with zero length.
    doReset();
    applyStimulus(1, 0, 0, 0, 8'h40, 1, 8'd4);
    checkOutput("bst_pend4", 32'(m3_pend), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 8'h00, 0, 8'd1);
    checkOutput("bst_pend0", 32'(m3_pend), 32'd0);
    checkOutput("bst_ok", 32'(m3_flags), 32'h00);
    applyStimulus(1, 0, 0, 0, 8'h44, 1, 8'd0);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
    checkOutput("bst_flags", 32'(m3_flags), 32'h40);
    checkOutput("bst_first", 32'(m3_first), 32'd6);
    checkOutput("bst_count", 32'(m3_count), 32'd1);

    // Command statistics: three reads (one stalled for two cycles) and two writes.
    doReset();
    applyStimulus(1, 0, 0, 0, 8'h50, 0, 8'd1);
    applyStimulus(0, 1, 0, 0, 8'h51, 0, 8'd1);
    applyStimulus(1, 0, 1, 0, 8'h52, 0, 8'd1);
    applyStimulus(1, 0, 1, 0, 8'h52, 0, 8'd1);
    applyStimulus(1, 0, 0, 0, 8'h52, 0, 8'd1);
    applyStimulus(0, 1, 0, 0, 8'h53, 0, 8'd1);
    applyStimulus(1, 0, 0, 0, 8'h54, 0, 8'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1);
`ifdef AVM_CHECKER_STATS_EN
    exp_rd = 32'd3;
    exp_wr = 32'd2;
`else
    exp_rd = 32'd0;
    exp_wr = 32'd0;
`endif
    checkOutput("stat_rd", m0_rdc, exp_rd);
    checkOutput("stat_wr", m0_wrc, exp_wr);
    checkOutput("stat_flags", 32'(m0_flags), 32'h00);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
